mem_tile_sram_ctrl: RTL

// - OBI subordinate driving the memory tile's banked SRAM array; sits downstream of the atomics resolver and replaces a pass-through shim.
// - Splits a DataWidth word across NumBanksPerWord = DataWidth/SramDataWidth parallel macros.
// - Selects one of NumBankRows macro rows and tracks in-flight accesses.
// - Buffers responses so R-channel backpressure (rready_i) never loses data.

---
 rtl/mem_tile_sram_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_tile_sram_ctrl.sv
// OBI subordinate for the memory tile's banked SRAM array, with an in-order response FIFO.
// Define MEM_TILE_SRAM_CTRL_STATS_EN to add saturating read/write/stall counters.
module mem_tile_sram_ctrl #(
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned IdWidth       = 3,
    parameter int unsigned SramDataWidth = 256,
    parameter int unsigned SramNumWords  = 512,
    parameter int unsigned NumBankRows   = 4,
    parameter int unsigned RspDepth      = 2,
    localparam int unsigned NumBanksPerWord = DataWidth / SramDataWidth,
    localparam int unsigned SramAddrW       = $clog2(SramNumWords)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic [AddrWidth-1:0]                  addr_i,
    input  logic                                  we_i,
    input  logic [DataWidth/8-1:0]                be_i,
    input  logic [DataWidth-1:0]                  wdata_i,
    input  logic [IdWidth-1:0]                    aid_i,
    output logic                                  rvalid_o,
    input  logic                                  rready_i,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic [IdWidth-1:0]                    rid_o,
    output logic                                  err_o,
    output logic [NumBankRows*NumBanksPerWord-1:0] sram_req_o,
    output logic                                  sram_we_o,
    output logic [SramAddrW-1:0]                  sram_addr_o,
    output logic [DataWidth-1:0]                  sram_wdata_o,
    output logic [DataWidth/8-1:0]                sram_be_o,
    input  logic [NumBankRows*DataWidth-1:0]      sram_rdata_i
`ifdef MEM_TILE_SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]                           stat_rd_o,
    output logic [31:0]                           stat_wr_o,
    output logic [31:0]                           stat_stall_o
`endif
);

    localparam int unsigned OffW    = $clog2(SramDataWidth / 8);
    localparam int unsigned BankW   = $clog2(NumBanksPerWord);
    localparam int unsigned RowW    = $clog2(NumBankRows);
    localparam int unsigned WordLsb = OffW + BankW;
    localparam int unsigned RowLsb  = WordLsb + SramAddrW;
    localparam int unsigned TopLsb  = RowLsb + RowW;
    localparam int unsigned CntW    = $clog2(RspDepth + 1);
    localparam int unsigned PtrW    = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntW-1:0] Depth   = CntW'(RspDepth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } rsp_t;

    logic                 addr_err;
    logic [RowW-1:0]      addr_row;
    logic                 accept;
    logic                 issue;
    logic                 pop;
    logic                 push;
    logic                 buf_pop;
    logic [CntW-1:0]      occ;
    logic [CntW-1:0]      count_d;
    logic                 unused_addr_lsbs;

    logic                 stage_valid_q;
    logic                 stage_we_q;
    logic                 stage_err_q;
    logic [IdWidth-1:0]   stage_id_q;
    logic [RowW-1:0]      stage_row_q;
    logic [CntW-1:0]      count_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    rsp_t                 rsp_mem_q [RspDepth];

    rsp_t                 stage_rsp;
    rsp_t                 head_rsp;
    logic [DataWidth-1:0] row_rdata [NumBankRows];

    assign addr_err         = (addr_i >> TopLsb) != '0;
    assign addr_row         = addr_i[RowLsb +: RowW];
    assign unused_addr_lsbs = ^addr_i[WordLsb-1:0];

    // A slot is reserved for every accepted access, so the stage always finds room when it pushes.
    assign occ     = count_q + CntW'(stage_valid_q);
    assign pop     = rvalid_o && rready_i;
    assign gnt_o   = !rst_i && ((occ < Depth) || pop);
    assign accept  = req_i && gnt_o;
    assign issue   = accept && !addr_err;

    assign sram_we_o    = issue ? we_i : 1'b0;
    assign sram_addr_o  = issue ? addr_i[WordLsb +: SramAddrW] : '0;
    assign sram_wdata_o = issue ? wdata_i : '0;
    assign sram_be_o    = issue ? be_i : '0;

    for (genvar gi = 0; gi < NumBankRows; gi++) begin : g_row
        assign sram_req_o[gi*NumBanksPerWord +: NumBanksPerWord] =
            {NumBanksPerWord{issue && (addr_row == RowW'(gi))}};
        assign row_rdata[gi] = sram_rdata_i[gi*DataWidth +: DataWidth];
    end

    always_comb begin
        stage_rsp       = '0;
        stage_rsp.id    = stage_id_q;
        stage_rsp.err   = stage_err_q;
        if (!stage_we_q && !stage_err_q) begin
            stage_rsp.rdata = row_rdata[stage_row_q];
        end
    end

    // With an empty buffer the stage entry is presented directly, giving one-cycle latency.
    assign head_rsp = (count_q != '0) ? rsp_mem_q[rd_ptr_q] : stage_rsp;
    assign rvalid_o = !rst_i && ((count_q != '0) || stage_valid_q);
    assign rdata_o  = rvalid_o ? head_rsp.rdata : '0;
    assign rid_o    = rvalid_o ? head_rsp.id : '0;
    assign err_o    = rvalid_o && head_rsp.err;

    assign push    = stage_valid_q && !((count_q == '0) && pop);
    assign buf_pop = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !buf_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && buf_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid_q <= 1'b0;
            stage_we_q    <= 1'b0;
            stage_err_q   <= 1'b0;
            stage_id_q    <= '0;
            stage_row_q   <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                stage_we_q  <= we_i;
                stage_err_q <= addr_err;
                stage_id_q  <= aid_i;
                stage_row_q <= addr_row;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (buf_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rsp_mem_q[wr_ptr_q] <= stage_rsp;
        end
    end

`ifdef MEM_TILE_SRAM_CTRL_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_rd_q    <= '0;
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (accept && !we_i && (stat_rd_q != '1)) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (accept && we_i && (stat_wr_q != '1)) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
            if (req_i && !gnt_o && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_rd_o    = stat_rd_q;
    assign stat_wr_o    = stat_wr_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule
